// File: rtl/bk_add_stage_pkg.sv
// Shared ALU definitions: operand width, op encoding and operand-select helpers.
// Pure constants and functions; no latency, no flow control.
package bk_add_stage_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_SBC = 2'd3
    } alu_op_e;

    function automatic logic op_inverts_b(alu_op_e op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    // Chained ops take the architectural carry; plain ops use a fixed carry-in.
    function automatic logic op_carry_in(alu_op_e op, logic carry);
        case (op)
            OP_ADD:  return 1'b0;
            OP_SUB:  return 1'b1;
            default: return carry;
        endcase
    endfunction

endpackage

// File: rtl/bk_add_stage_adder.sv
// 64-bit Brent-Kung parallel-prefix adder with carry-in, purely combinational.
// Zero latency, no flow control.
module BrentKungAdder64Bit
    import bk_add_stage_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o
);

    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] gp;

    always_comb begin
        p  = a_i ^ b_i;
        g  = a_i & b_i;
        gp = p;
        // Fold carry-in into bit 0 so g[i] ends up as the carry out of bit i.
        g[0] = g[0] | (p[0] & cin_i);
        for (int d = 0; d < 6; d++) begin
            for (int i = (2 << d) - 1; i < DATA_W; i += (2 << d)) begin
                g[6'(i)]  = g[6'(i)] | (gp[6'(i)] & g[6'(i - (1 << d))]);
                gp[6'(i)] = gp[6'(i)] & gp[6'(i - (1 << d))];
            end
        end
        for (int d = 4; d >= 0; d--) begin
            for (int i = (3 << d) - 1; i < DATA_W; i += (2 << d)) begin
                g[6'(i)]  = g[6'(i)] | (gp[6'(i)] & g[6'(i - (1 << d))]);
                gp[6'(i)] = gp[6'(i)] & gp[6'(i - (1 << d))];
            end
        end
        sum_o  = p ^ {g[DATA_W-2:0], cin_i};
        cout_o = g[DATA_W-1];
    end

endmodule

// File: rtl/bk_add_stage.sv
// Two-stage elastic add/sub pipeline with NZCV flags and a chained carry flag.
// Latency 2 edges, 1 op/cycle; S2 holds on out_ready low and S1 holds behind it.
module bk_add_stage
    import bk_add_stage_pkg::*;
#(
    parameter int DATA_W = bk_add_stage_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    input  logic              flag_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_c,
    output logic              out_v,
    output logic              out_z,
    output logic              out_n,
    output logic              carry_flag
);

    if (DATA_W != 64) begin : g_bad_width
        $error("bk_add_stage: DATA_W must be 64");
    end

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    alu_op_e           op_q, op_d;
    logic              s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
    logic              c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
    logic              carry_q, carry_d;

    logic              advance;
    logic [DATA_W-1:0] b_eff, add_sum;
    logic              cin, add_cout;

    always_comb begin
        advance  = s1_vld_q && (!out_vld_q || out_ready);
        in_ready = !s1_vld_q || advance;
        b_eff    = op_inverts_b(op_q) ? ~b_q : b_q;
        cin      = op_carry_in(op_q, carry_q);
    end

    BrentKungAdder64Bit u_adder (
        .a_i    (a_q),
        .b_i    (b_eff),
        .cin_i  (cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        s1_vld_d  = s1_vld_q;
        sum_d     = sum_q;
        c_d       = c_q;
        v_d       = v_q;
        z_d       = z_q;
        n_d       = n_q;
        out_vld_d = out_vld_q;
        carry_d   = carry_q;

        if (in_valid && in_ready) begin
            a_d      = in_a;
            b_d      = in_b;
            op_d     = alu_op_e'(in_op);
            s1_vld_d = 1'b1;
        end else if (advance) begin
            s1_vld_d = 1'b0;
        end

        if (advance) begin
            sum_d     = add_sum;
            c_d       = add_cout;
            v_d       = (a_q[DATA_W-1] == b_eff[DATA_W-1]) && (add_sum[DATA_W-1] != a_q[DATA_W-1]);
            z_d       = (add_sum == '0);
            n_d       = add_sum[DATA_W-1];
            out_vld_d = 1'b1;
            carry_d   = add_cout;
        end else begin
            if (out_ready) out_vld_d = 1'b0;
            if (flag_clr)  carry_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            s1_vld_q  <= 1'b0;
            sum_q     <= '0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            out_vld_q <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            s1_vld_q  <= s1_vld_d;
            sum_q     <= sum_d;
            c_q       <= c_d;
            v_q       <= v_d;
            z_q       <= z_d;
            n_q       <= n_d;
            out_vld_q <= out_vld_d;
            carry_q   <= carry_d;
        end
    end

    assign out_valid  = out_vld_q;
    assign out_sum    = sum_q;
    assign out_c      = c_q;
    assign out_v      = v_q;
    assign out_z      = z_q;
    assign out_n      = n_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_bk_add_stage.sv
// Scoreboarded bench: driver pushes reference results, negedge monitor pops on each output transfer.
module tb_bk_add_stage;
    import bk_add_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flag_clr, out_valid, out_ready;
    logic [63:0] in_a, in_b, out_sum;
    logic [1:0]  in_op;
    logic        out_c, out_v, out_z, out_n, carry_flag;

    always #5 clk = ~clk;

    bk_add_stage #(.DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .flag_clr   (flag_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_c      (out_c),
        .out_v      (out_v),
        .out_z      (out_z),
        .out_n      (out_n),
        .carry_flag (carry_flag)
    );

    int          errors = 0;
    int          checks = 0;
    logic [67:0] exp_q[$];
    bit          model_carry = 1'b0;
    bit          rnd_done;

    localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINS = 64'h8000_0000_0000_0000;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result packed as {sum, c, v, z, n}, computed with plain 65-bit arithmetic.
    function automatic logic [67:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] op, input bit cf);
        logic [63:0] be;
        logic [64:0] wide;
        logic [63:0] s;
        bit          ci;
        case (op)
            2'd0:    begin be = b;  ci = 1'b0; end
            2'd1:    begin be = ~b; ci = 1'b1; end
            2'd2:    begin be = b;  ci = cf;   end
            default: begin be = ~b; ci = cf;   end
        endcase
        wide = {1'b0, a} + {1'b0, be} + {64'd0, ci};
        s    = wide[63:0];
        return {s, wide[64], (a[63] == be[63]) && (s[63] != a[63]), s == 64'd0, s[63]};
    endfunction

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        int          waited;
        logic [67:0] e;
        waited   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) break;
            @(posedge clk);
            #1;
        end
        if (!in_ready) begin
            chk("send_timeout", 68'(in_ready), 68'd1);
        end else begin
            e           = ref_op(a, b, op, model_carry);
            model_carry = e[3];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_op    = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_left", 68'(exp_q.size()), 68'd0);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return MAXV;
            1:       return MINS;
            2:       return 64'd0;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: compares every output transfer and checks S2 holds steady while stalled.
    logic [67:0] held;
    bit          stalled = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 68'(out_valid), 68'd1);
                chk("stall_hold", {out_sum, out_c, out_v, out_z, out_n}, held);
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no output",
                             {out_sum, out_c, out_v, out_z, out_n});
                end else begin
                    chk("result", {out_sum, out_c, out_v, out_z, out_n}, exp_q.pop_front());
                end
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = {out_sum, out_c, out_v, out_z, out_n};
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        flag_clr  = 1'b0;
        out_ready = 1'b0;
        rnd_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 68'(out_valid), 68'd0);
        chk("rst_outputs", {out_sum, out_c, out_v, out_z, out_n}, 68'd0);
        chk("rst_carry", 68'(carry_flag), 68'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 68'(in_ready), 68'd1);
        out_ready = 1'b1;

        // Wrap to zero with carry, then signed overflow on subtract.
        send(MAXV, 64'd1, OP_ADD);
        @(posedge clk);
        #1;
        chk("wrap_carry_flag", 68'(carry_flag), 68'd1);
        send(MINS, 64'd1, OP_SUB);
        // 128-bit add across two ops.
        send(MAXV, 64'd1, OP_ADD);
        send(64'd0, 64'd0, OP_ADC);
        drain();

        // Stall: two ops buffered, third refused until out_ready returns.
        out_ready = 1'b0;
        fork
            begin
                send(64'd10, 64'd20, OP_ADD);
                send(64'd5, 64'd7, OP_SUB);
                send(MAXV, MAXV, OP_ADC);
            end
            begin
                repeat (5) @(negedge clk);
                chk("stall_in_ready", 68'(in_ready), 68'd0);
                chk("stall_in_valid_out_valid", {66'd0, in_valid, out_valid}, 68'd3);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // flag_clr loses to a concurrent advance, wins when alone.
        send(MAXV, 64'd2, OP_ADD);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_vs_advance", 68'(carry_flag), 68'd1);
        @(posedge clk);
        #1;
        flag_clr    = 1'b0;
        model_carry = 1'b0;
        chk("clr_alone", 68'(carry_flag), 68'd0);
        send(64'd3, 64'd4, OP_ADC);
        drain();

        // Reset with both stages full discards everything in flight.
        out_ready = 1'b0;
        send(MAXV, 64'd1, OP_ADD);
        send(MAXV, 64'd1, OP_ADD);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_carry = 1'b0;
        rst_n       = 1'b1;
        chk("rst2_out_valid", 68'(out_valid), 68'd0);
        chk("rst2_carry", 68'(carry_flag), 68'd0);
        chk("rst2_in_ready", 68'(in_ready), 68'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Random traffic with random downstream backpressure.
        fork
            begin
                for (int k = 0; k < 400; k++) begin
                    send(pick_operand(), pick_operand(), 2'($urandom_range(0, 3)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #0;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
